// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: divide opcode encodings,
// the load encoding of ResultSrc, divider FSM states and small decode helpers.
package pipeline_hazard_ctrl_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_RUN  = 2'b01,
      DIV_DONE = 2'b10
   } divState_t;

   // DIV and REM are signed, DIVU and REMU are not
   function automatic logic opIsSigned(input logic [1:0] op);
      return ~op[0];
   endfunction

   // REM/REMU return the remainder, DIV/DIVU the quotient
   function automatic logic opIsRem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_div_iter_core.sv
// Unsigned restoring divider datapath: start loads the operands, each step
// produces one quotient bit (MSB first). Quotient shifts in where the
// dividend shifts out, so the dividend register doubles as the quotient.
module div_iter_core
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] quoReg;
   logic [XLEN-1:0] remReg;
   logic [XLEN-1:0] divReg;
   logic [XLEN:0]   remShift;
   logic [XLEN:0]   trialDiff;

   // Trial subtraction of the divisor from the shifted partial remainder
   always_comb begin
      remShift  = {remReg, quoReg[XLEN-1]};
      trialDiff = remShift - {1'b0, divReg};
   end

   // Operand load on start, one restoring iteration per step
   always_ff @(posedge clk) begin
      if (rst) begin
         quoReg <= '0;
         remReg <= '0;
         divReg <= '0;
      end else if (start) begin
         quoReg <= dividend;
         remReg <= '0;
         divReg <= divisor;
      end else if (step) begin
         if (!trialDiff[XLEN]) begin
            remReg <= trialDiff[XLEN-1:0];
            quoReg <= {quoReg[XLEN-2:0], 1'b1};
         end else begin
            remReg <= remShift[XLEN-1:0];
            quoReg <= {quoReg[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quoReg;
   assign remainder = remReg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use interlock,
// branch/jump flush and sequencing of the iterative divider in Execute.
// Optional macro HAZARD_PERF_CNT_EN adds a stall_cycles performance counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      Rs1_D,
   input  logic [4:0]      Rs2_D,
   input  logic [4:0]      RD_E,
   input  logic            MemReadE,
   input  logic            PCSrcE,
   input  logic            JumpE,
   input  logic            DivE,
   input  logic [1:0]      DivOpE,
   input  logic [XLEN-1:0] SrcA_E,
   input  logic [XLEN-1:0] SrcB_E,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            FlushD,
   output logic            FlushE,
   output logic            BubbleM,
   output logic [XLEN-1:0] DivResultE,
   output logic            DivValidE,
   output logic            div_busy
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0]    stall_cycles
`endif
);

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] negateIf(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

   divState_t         state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic              start, step, latch;
   logic [1:0]        opReg;
   logic              negQReg, negRReg, fastReg;
   logic [XLEN-1:0]   fastValReg;

   logic              isSignedOp, isRemOp, srcANeg, srcBNeg;
   logic              divZero, overflow, fastPath;
   logic [XLEN-1:0]   magA, magB, fastValue;
   logic [XLEN-1:0]   coreQ, coreR, finalQ, finalR;
   logic              lwStall, branchFlush, divStall;

   // Operand decode: magnitudes for the unsigned core and the fast-path results
   always_comb begin
      isSignedOp = opIsSigned(DivOpE);
      isRemOp    = opIsRem(DivOpE);
      srcANeg    = isSignedOp & SrcA_E[XLEN-1];
      srcBNeg    = isSignedOp & SrcB_E[XLEN-1];
      magA       = negateIf(srcANeg, SrcA_E);
      magB       = negateIf(srcBNeg, SrcB_E);
      divZero    = (SrcB_E == '0);
      overflow   = isSignedOp & (SrcA_E == INT_MIN) & (SrcB_E == '1);
      fastPath   = divZero | overflow;
      if (divZero) fastValue = isRemOp ? SrcA_E : '1;
      else         fastValue = isRemOp ? '0 : INT_MIN;
   end

   // Divider FSM next-state and core sequencing
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      start     = 1'b0;
      step      = 1'b0;
      latch     = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (DivE) begin
               latch   = 1'b1;
               cntNext = CNT_W'(DIV_CYCLES - 1);
               if (fastPath) begin
                  stateNext = DIV_DONE;
               end else begin
                  start     = 1'b1;
                  stateNext = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            step = 1'b1;
            if (cnt == '0) stateNext = DIV_DONE;
            else           cntNext   = cnt - 1'b1;
         end
         DIV_DONE: stateNext = DIV_IDLE;
         default:  stateNext = DIV_IDLE;
      endcase
   end

   // FSM state, iteration counter and per-instruction sign/fast-path capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DIV_IDLE;
         cnt        <= '0;
         opReg      <= '0;
         negQReg    <= 1'b0;
         negRReg    <= 1'b0;
         fastReg    <= 1'b0;
         fastValReg <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (latch) begin
            opReg      <= DivOpE;
            negQReg    <= srcANeg ^ srcBNeg;
            negRReg    <= srcANeg;
            fastReg    <= fastPath;
            fastValReg <= fastValue;
         end
      end
   end

   div_iter_core #(.XLEN(XLEN)) uCore (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .step      (step),
      .dividend  (magA),
      .divisor   (magB),
      .quotient  (coreQ),
      .remainder (coreR)
   );

   // Sign fix-up of the unsigned result, fast-path override, result gating
   always_comb begin
      finalQ     = negateIf(negQReg, coreQ);
      finalR     = negateIf(negRReg, coreR);
      DivValidE  = (state == DIV_DONE);
      div_busy   = (state != DIV_IDLE);
      DivResultE = '0;
      if (DivValidE) begin
         if (fastReg)              DivResultE = fastValReg;
         else if (opIsRem(opReg))  DivResultE = finalR;
         else                      DivResultE = finalQ;
      end
   end

   // Hazard resolution: a taken branch/jump overrides a load-use stall
   always_comb begin
      lwStall     = MemReadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
      branchFlush = PCSrcE | JumpE;
      divStall    = DivE & (state != DIV_DONE);
      StallF      = divStall | (lwStall & ~branchFlush);
      StallD      = divStall | (lwStall & ~branchFlush);
      StallE      = divStall;
      BubbleM     = divStall;
      FlushD      = branchFlush;
      FlushE      = branchFlush | lwStall;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Free-running count of fetch-stall cycles, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)         stall_cycles <= '0;
      else if (StallF) stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: hazard vector table plus
// divide sequences checked through a result scoreboard.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  Rs1_D, Rs2_D, RD_E;
   logic        MemReadE, PCSrcE, JumpE, DivE;
   logic [1:0]  DivOpE;
   logic [31:0] SrcA_E, SrcB_E;
   logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM;
   logic [31:0] DivResultE;
   logic        DivValidE, div_busy;

   int nVec  = 0;
   int nFail = 0;
   logic [31:0] expQ[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
      .MemReadE(MemReadE), .PCSrcE(PCSrcE), .JumpE(JumpE), .DivE(DivE),
      .DivOpE(DivOpE), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
      .FlushE(FlushE), .BubbleM(BubbleM), .DivResultE(DivResultE),
      .DivValidE(DivValidE), .div_busy(div_busy)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       memRead, pcSrc, jump;
      logic [5:0] expCtl;   // {StallF,StallD,StallE,FlushD,FlushE,BubbleM}
   } hazVec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic sgn, rem;
      sgn = ~op[0];
      rem = op[1];
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return rem ? a % b : a / b;
   endfunction

   // Drives one divide at posedge+1, checks result, latency and stall profile
   task automatic runDiv(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes);
      int  k, stalls, bubbleMis, expLat;
      bit  seen;
      logic [31:0] want;
      expLat = ((b == 32'd0) || (~op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
      DivE = 1'b1; DivOpE = op; SrcA_E = a; SrcB_E = b;
      expQ.push_back(expRes);
      stalls = 0; bubbleMis = 0; seen = 1'b0;
      for (k = 0; k < 100 && !seen; k++) begin
         #1;
         if (StallF) stalls++;
         if (BubbleM !== StallF || StallE !== StallF || StallD !== StallF) bubbleMis++;
         if (DivValidE === 1'b1) begin
            seen = 1'b1;
            want = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
            chk({name, "_result"}, DivResultE, want);
            chk({name, "_latency"}, k + 1, expLat);
            chk({name, "_stallF_cycles"}, stalls, expLat - 1);
            chk({name, "_bubble_track"}, bubbleMis, 0);
            DivE = 1'b0;
         end
         @(posedge clk);
      end
      if (!seen) begin
         chk({name, "_timeout"}, 0, 1);
         DivE = 1'b0;
         expQ.delete();
      end
      #1;
   endtask

   initial begin
      hazVec_t vecs[$];
      int pulses;
      logic [31:0] ra, rb;
      logic [1:0]  rop;

      vecs.push_back('{5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 6'b110010});
      vecs.push_back('{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 6'b110010});
      vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000000});
      vecs.push_back('{5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 6'b000000});
      vecs.push_back('{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000000});
      vecs.push_back('{5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 6'b000110});
      vecs.push_back('{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 6'b000110});
      vecs.push_back('{5'd2, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 6'b000110});
      vecs.push_back('{5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 6'b000110});

      rst = 1'b1; Rs1_D = '0; Rs2_D = '0; RD_E = '0; MemReadE = 1'b0;
      PCSrcE = 1'b0; JumpE = 1'b0; DivE = 1'b0; DivOpE = '0; SrcA_E = '0; SrcB_E = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ctl", {26'd0, StallF, StallD, StallE, FlushD, FlushE, BubbleM}, 32'd0);
      chk("reset_div", {29'd0, DivValidE, div_busy, 1'b0}, 32'd0);
      chk("reset_result", DivResultE, 32'd0);

      foreach (vecs[i]) begin
         Rs1_D = vecs[i].rs1; Rs2_D = vecs[i].rs2; RD_E = vecs[i].rd;
         MemReadE = vecs[i].memRead; PCSrcE = vecs[i].pcSrc; JumpE = vecs[i].jump;
         #1;
         chk($sformatf("hazard_vec%0d", i),
             {26'd0, StallF, StallD, StallE, FlushD, FlushE, BubbleM}, {26'd0, vecs[i].expCtl});
         @(posedge clk); #1;
      end

      // lw x5 then add x6,x5,x1: one stall cycle, then the bubble leaves Execute
      Rs1_D = 5'd5; Rs2_D = 5'd1; RD_E = 5'd5; MemReadE = 1'b1; PCSrcE = 1'b0; JumpE = 1'b0;
      #1 chk("loaduse_cycle1", {29'd0, StallF, StallD, FlushE}, 32'b111);
      @(posedge clk); #1;
      RD_E = 5'd0; MemReadE = 1'b0;
      #1 chk("loaduse_cycle2", {29'd0, StallF, StallD, FlushE}, 32'b000);
      Rs1_D = '0; Rs2_D = '0;
      @(posedge clk); #1;

      runDiv("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14);
      runDiv("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
      runDiv("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
      runDiv("divu_x_0",     2'b01, 32'd12345,      32'd0,          32'hFFFF_FFFF);
      runDiv("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5);
      runDiv("div_m100_7",   2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2);
      runDiv("rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2);
      runDiv("rem_m9_0",     2'b10, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7);
      runDiv("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
      runDiv("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom_range(1, 32'h00FF_FFFF); rop = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
         runDiv($sformatf("rand%0d", i), rop, ra, rb, refDiv(rop, ra, rb));
      end

      // Reset during RUN aborts the divide without a result pulse
      DivE = 1'b1; DivOpE = 2'b00; SrcA_E = 32'd1000; SrcB_E = 32'd3;
      repeat (11) @(posedge clk);
      #1 chk("abort_busy_before", {31'd0, div_busy}, 32'd1);
      rst = 1'b1; DivE = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      chk("abort_busy_after", {31'd0, div_busy}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (DivValidE === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      chk("abort_no_valid", pulses, 0);
      runDiv("div_after_abort", 2'b00, 32'd1000, 32'd3, 32'd333);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
